// File: rtl/cla_pipe_adder.sv
// Three-stage pipelined two-level carry-lookahead adder/subtractor with valid/ready flow control.
// S1 forms per-bit generate/propagate, S2 resolves group carries, S3 forms the sum and flags.
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NG = WIDTH / GROUP;

  if ((WIDTH % GROUP) != 0 || WIDTH < GROUP || GROUP < 2 || GROUP > 8) begin : g_bad_params
    $error("cla_pipe_adder: WIDTH must be a multiple of GROUP and GROUP must lie in 2..8");
  end

  // Group generate: g[k] | p[k]g[k-1] | ... | p[k]..p[lo+1]g[lo]
  function automatic logic grp_gen(input logic [GROUP-1:0] gs, input logic [GROUP-1:0] ps);
    logic r, pr;
    r  = 1'b0;
    pr = 1'b1;
    for (int k = GROUP - 1; k >= 0; k--) begin
      r  = r | (pr & gs[k]);
      pr = pr & ps[k];
    end
    return r;
  endfunction

  function automatic logic grp_prop(input logic [GROUP-1:0] ps);
    return &ps;
  endfunction

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic [WIDTH-1:0] b_eff;
  assign b_eff = sub ? ~b : b;

  logic             s1_valid;
  logic             s1_c0;
  logic [WIDTH-1:0] s1_g;
  logic [WIDTH-1:0] s1_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_c0    <= 1'b0;
      s1_g     <= '0;
      s1_p     <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_c0    <= sub | cin;
      s1_g     <= a & b_eff;
      s1_p     <= a ^ b_eff;
    end
  end

  // Each group carry is a flat OR of (propagate run) & (group generate) terms plus the c0 term.
  logic [NG-1:0] grp_c;
  logic          term;
  logic          prod;

  always_comb begin
    grp_c    = '0;
    term     = 1'b0;
    prod     = 1'b1;
    grp_c[0] = s1_c0;
    for (int j = 1; j < NG; j++) begin
      term = 1'b0;
      prod = 1'b1;
      for (int m = j - 1; m >= 0; m--) begin
        term = term | (prod & grp_gen(s1_g[m*GROUP +: GROUP], s1_p[m*GROUP +: GROUP]));
        prod = prod & grp_prop(s1_p[m*GROUP +: GROUP]);
      end
      grp_c[j] = term | (prod & s1_c0);
    end
  end

  logic             s2_valid;
  logic [WIDTH-1:0] s2_g;
  logic [WIDTH-1:0] s2_p;
  logic [NG-1:0]    s2_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_g     <= '0;
      s2_p     <= '0;
      s2_c     <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_g     <= s1_g;
      s2_p     <= s1_p;
      s2_c     <= grp_c;
    end
  end

  // Carries restart from the registered group carry at every group's low bit.
  logic [WIDTH-1:0] sum_n;
  logic             carry;
  logic             msb_cin;
  logic             cout_n;
  logic             ovf_n;

  always_comb begin
    sum_n   = '0;
    carry   = 1'b0;
    msb_cin = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if ((i % GROUP) == 0) carry = s2_c[i / GROUP];
      if (i == WIDTH - 1) msb_cin = carry;
      sum_n[i] = s2_p[i] ^ carry;
      carry    = s2_g[i] | (s2_p[i] & carry);
    end
    cout_n = carry;
    ovf_n  = msb_cin ^ carry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_valid;
      sum       <= sum_n;
      cout      <= cout_n;
      ovf       <= ovf_n;
    end
  end

endmodule
